// File: rtl/fifo_wr_arbiter_if.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter_if
//   Bundles the producer handshakes, the async_fifo write port and the
//   debug/status outputs of fifo_wr_arbiter.
//
//   Signals:
//     req_valid  [NUM_REQ]             per-requester word available
//     req_data   [NUM_REQ*DATA_WIDTH]  packed data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//     req_ready  [NUM_REQ]             per-requester accept
//     wr_en, din                       to async_fifo write port
//     full, wr_ack, wr_err             from async_fifo
//     gnt_valid, gnt_id[3]             current grant
//     xfer_cnt[16], err_cnt[8]         debug counters
//
//   Modports:
//     master : the arbiter
//     slave  : the environment (producers + FIFO)
// -----------------------------------------------------------------------------
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          wr_en;
  logic [DATA_WIDTH-1:0]         din;
  logic                          full;
  logic                          wr_ack;
  logic                          wr_err;
  logic                          gnt_valid;
  logic [2:0]                    gnt_id;
  logic [15:0]                   xfer_cnt;
  logic [7:0]                    err_cnt;

  modport master (
    input  req_valid, req_data, full, wr_ack, wr_err,
    output req_ready, wr_en, din, gnt_valid, gnt_id, xfer_cnt, err_cnt
  );

  modport slave (
    output req_valid, req_data, full, wr_ack, wr_err,
    input  req_ready, wr_en, din, gnt_valid, gnt_id, xfer_cnt, err_cnt
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//   Write-side scheduler for async_fifo (wr_clk domain only). Shares the single
//   FIFO write port among NUM_REQ valid/ready producers using round-robin
//   grants limited to MAX_BURST words each. Never writes while the FIFO is
//   full, and keeps debug counters of acknowledged writes and write errors.
//
//   Ports:
//     wr_clk  write-domain clock
//     clear   synchronous active-high reset
//     bus     fifo_wr_arbiter_if.master (handshakes, FIFO port, status)
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input logic                wr_clk,
  input logic                clear,
  fifo_wr_arbiter_if.master  bus
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);
  localparam logic [2:0] LAST_ID    = 3'(NUM_REQ - 1);
  localparam logic [3:0] NUM_REQ_W  = 4'(NUM_REQ);

  logic [0:0]            state;
  logic [2:0]            gnt_id_q;
  logic [2:0]            rr_ptr;
  logic [3:0]            burst_cnt;
  logic [15:0]           xfer_q;
  logic [7:0]            err_q;

  logic                  gnt_valid;
  logic                  cur_valid;
  logic [DATA_WIDTH-1:0] cur_data;
  logic                  wr_en;
  logic                  grant_end;
  logic [2:0]            next_rr;
  logic [2:0]            search_base;
  logic [2*NUM_REQ-1:0]  rot_valid;
  logic [2:0]            pick_off;
  logic [3:0]            pick_sum;
  logic [2:0]            pick_id;
  logic                  any_valid;
  logic [NUM_REQ-1:0]    ready;

  assign gnt_valid = (state == GRANT);
  assign any_valid = |bus.req_valid;

  // Select the granted requester's valid/data with constant indices so the
  // 3-bit grant id never has to index a narrower vector directly.
  // NOTE: every always_comb output gets a default first, otherwise a path
  // that skips the assignment infers a latch.
  always_comb begin
    cur_valid = 1'b0;
    cur_data  = '0;
    ready     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_id_q == 3'(i)) begin
        cur_valid = bus.req_valid[i];
        cur_data  = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
        ready[i]  = gnt_valid & ~bus.full;
      end
    end
  end

  assign wr_en = gnt_valid & cur_valid & ~bus.full;

  // A full FIFO freezes the grant; otherwise it ends on the last word of the
  // burst or when the owner has nothing to send.
  assign grant_end = gnt_valid & ~bus.full &
                     (~cur_valid | (burst_cnt == BURST_LAST));

  assign next_rr = (gnt_id_q == LAST_ID) ? 3'd0 : gnt_id_q + 3'd1;

  // Round-robin search: rotate the valid vector so the search base sits at
  // bit 0 and take the lowest set bit. Starting at gnt_id+1 on grant end puts
  // the retiring requester last, so it only wins if nobody else is valid.
  always_comb begin
    search_base = grant_end ? next_rr : rr_ptr;
    rot_valid   = {bus.req_valid, bus.req_valid} >> search_base;
    pick_off    = 3'd0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot_valid[k]) pick_off = 3'(k);
    end
    pick_sum = {1'b0, search_base} + {1'b0, pick_off};
    pick_id  = (pick_sum >= NUM_REQ_W) ? 3'(pick_sum - NUM_REQ_W)
                                       : pick_sum[2:0];
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; clear is checked inside the clocked block,
  // making the reset synchronous.
  always_ff @(posedge wr_clk) begin
    if (clear) begin
      state     <= IDLE;
      gnt_id_q  <= 3'd0;
      rr_ptr    <= 3'd0;
      burst_cnt <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            state     <= GRANT;
            gnt_id_q  <= pick_id;
            burst_cnt <= 4'd0;
          end
        end
        GRANT: begin
          if (grant_end) begin
            rr_ptr    <= next_rr;
            burst_cnt <= 4'd0;
            if (any_valid) begin
              gnt_id_q <= pick_id;
            end else begin
              state <= IDLE;
            end
          end else if (wr_en) begin
            burst_cnt <= burst_cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Debug counters track the FIFO's own responses, independent of the FSM.
  always_ff @(posedge wr_clk) begin
    if (clear) begin
      xfer_q <= 16'd0;
      err_q  <= 8'd0;
    end else begin
      if (bus.wr_ack) xfer_q <= xfer_q + 16'd1;
      if (bus.wr_err && (err_q != 8'hFF)) err_q <= err_q + 8'd1;
    end
  end

  assign bus.req_ready = ready;
  assign bus.wr_en     = wr_en;
  assign bus.din       = gnt_valid ? cur_data : '0;
  assign bus.gnt_valid = gnt_valid;
  assign bus.gnt_id    = gnt_id_q;
  assign bus.xfer_cnt  = xfer_q;
  assign bus.err_cnt   = err_q;

endmodule
